branch_stage: RTL and testbench
===============================

# branch_stage

Clocked branch stage for the data-driven pipeline; the counterpart of the merge stage. Takes one packet stream over a Send/Ack four-phase handshake and routes each packet to one of two output channels: A (internal) or B (external). The channel is chosen by a routing bit in the packet. Each output channel holds one packet in its own data latch, so an idle channel never holds back the upstream stage, except when the next packet is for the busy channel.

## Interface
- SEL_BIT, default `M_PACKET_WIDTH`-1: index of the routing bit in the packet. 0 selects channel A, 1 selects channel B.
- CLK  in  1  stage clock; all state updates on rising edge.
- MR_N  in  1  master reset, synchronous, active-low.
- Send_in  in  1  upstream request; packet valid while high.
- Ack_out  out  1  upstream acknowledge.
- PACKET_IN  in  `M_PACKET_SIZE`  upstream packet.
- Send_out_a, Send_out_b  out  1  request to internal / external consumer.
- Ack_in_a, Ack_in_b  in  1  acknowledge from internal / external consumer.
- PACKET_OUT_A, PACKET_OUT_B  out  `M_PACKET_SIZE`  latched packet per channel (DL_A, DL_B).

All handshake inputs are synchronous to CLK.

## Operation
- **Input FSM**, states IN_WAIT and IN_ACK.
  - IN_WAIT → IN_ACK when Send_in=1 and the target channel FSM is OUT_IDLE. The target is PACKET_IN[SEL_BIT].
  - On that edge the stage captures PACKET_IN into DL_A or DL_B and drives Ack_out=1.
  - IN_ACK → IN_WAIT when Send_in=0; Ack_out returns to 0.
- **Output FSM per channel x**, states OUT_IDLE, OUT_REQ and OUT_RTZ.
  - OUT_IDLE → OUT_REQ on capture into DL_x; Send_out_x=1.
  - OUT_REQ → OUT_RTZ when Ack_in_x=1; Send_out_x=0.
  - OUT_RTZ → OUT_IDLE when Ack_in_x=0. The slot is free again.
- Head-of-line blocking: if the target channel is not OUT_IDLE, the stage holds Ack_out at 0 and leaves PACKET_IN uncaptured, even if the other channel is idle.
- DL_x changes only on capture. PACKET_OUT_x is stable from Send_out_x rising until the channel returns to OUT_IDLE.
- Ack_in_x=1 while the channel is in OUT_IDLE is ignored.
- Send_in falling before Ack_out is a protocol violation. It is ignored: the FSM stays in IN_WAIT and nothing is captured.
- The two channels run their handshakes independently and concurrently.

## Timing
- Reset: MR_N=0 sampled at an edge puts every FSM in its idle state. After that edge:
  - Ack_out=0, Send_out_a=0, Send_out_b=0.
  - DL_A=0 and DL_B=0, so PACKET_OUT_A=0 and PACKET_OUT_B=0.
- Reset mid-operation abandons any in-flight handshake without completing it. Reset takes priority over every other transition.
- Latency: Send_in is sampled high at edge N with the target channel idle. Ack_out and Send_out_x are both high after edge N, with PACKET_OUT_x valid (one cycle).
- Output cycle: one edge per transition, so at least 3 edges from capture to OUT_IDLE.
- A new capture into the same channel is possible at the earliest on the edge after the channel enters OUT_IDLE.
- Upstream throughput: one packet per 2 cycles at best (IN_WAIT → IN_ACK → IN_WAIT).
- Simultaneous events:
  - Capture into A and completion of B in the same edge are both performed.
  - The OUT_RTZ → OUT_IDLE transition and a capture into that same channel never coincide.

## Configuration
- BRANCH_STAGE_STRIP_EN defined: on capture, bit SEL_BIT of the latched packet is forced to 0. Downstream stages see a packet with the routing bit cleared.
- BRANCH_STAGE_STRIP_EN undefined: the packet is latched unmodified.
- Routing always uses the unmodified PACKET_IN[SEL_BIT] in both builds.

## Test plan
All scenarios use `M_PACKET_WIDTH`=32 and SEL_BIT=31.
- **Reset.** Hold MR_N=0 for 2 edges with Send_in=1 and PACKET_IN=32'hFFFF_FFFF → all outputs 0; after MR_N=1, capture occurs on the next edge.
- **Route to A.** PACKET_IN=32'h0000_1234 with Send_in=1 → next edge: Ack_out=1, Send_out_a=1, PACKET_OUT_A=32'h0000_1234, Send_out_b=0. Then cycle Ack_in_a 1→0 → Send_out_a falls one edge after Ack_in_a rises; channel idle one edge after Ack_in_a falls.
- **Route to B with strip.** PACKET_IN=32'h8000_00AB → Send_out_b=1 after one edge. PACKET_OUT_B=32'h0000_00AB with BRANCH_STAGE_STRIP_EN defined; 32'h8000_00AB without it.
- **Blocking.** B is held in OUT_REQ (Ack_in_b=0). Send a second packet 32'h8000_0001 → Ack_out stays 0 for 10 cycles. Raise Ack_in_b, then lower it → capture occurs the edge after B returns to OUT_IDLE.
- **Concurrency.** Packet for A, then a packet for B while A is still in OUT_REQ → both Send_out_a and Send_out_b are high together; each channel completes independently.
- **Mid-operation reset.** Assert MR_N=0 while A is in OUT_REQ and the input FSM is in IN_ACK → all outputs 0 after that edge; a stray Ack_in_a=1 afterwards is ignored.

Source files
------------

// File: rtl/branch_stage_if.sv
// branch_stage_if
//   Handshake and packet bundle around the branch stage.
//   Upstream side : Send_in, PACKET_IN in; Ack_out out.
//   Channel A     : Send_out_a, PACKET_OUT_A out; Ack_in_a in (internal consumer).
//   Channel B     : Send_out_b, PACKET_OUT_B out; Ack_in_b in (external consumer).
//   Modports: slave = the branch stage, master = the environment around it.
//   Packet width comes from `M_PACKET_SIZE (defaults to 32 when not supplied).

`ifndef M_PACKET_WIDTH
`define M_PACKET_WIDTH 32
`endif
`ifndef M_PACKET_SIZE
`define M_PACKET_SIZE `M_PACKET_WIDTH
`endif

interface branch_stage_if;
   logic                        Send_in;
   logic                        Ack_out;
   logic [`M_PACKET_SIZE-1:0]   PACKET_IN;
   logic                        Send_out_a;
   logic                        Send_out_b;
   logic                        Ack_in_a;
   logic                        Ack_in_b;
   logic [`M_PACKET_SIZE-1:0]   PACKET_OUT_A;
   logic [`M_PACKET_SIZE-1:0]   PACKET_OUT_B;

   modport slave (
      input  Send_in, PACKET_IN, Ack_in_a, Ack_in_b,
      output Ack_out, Send_out_a, Send_out_b, PACKET_OUT_A, PACKET_OUT_B
   );

   modport master (
      output Send_in, PACKET_IN, Ack_in_a, Ack_in_b,
      input  Ack_out, Send_out_a, Send_out_b, PACKET_OUT_A, PACKET_OUT_B
   );
endinterface

// File: rtl/branch_stage.sv
// branch_stage
//   Routes each upstream packet to channel A (routing bit 0) or channel B
//   (routing bit 1). Each channel owns one data latch and a four-phase
//   output handshake, so the channels run independently; upstream is only
//   stalled when the packet targets a channel that is still busy.
//   Ports: CLK, MR_N (synchronous, active-low), bus (branch_stage_if.slave).
//   Parameter SEL_BIT: index of the routing bit in PACKET_IN.
//   Optional macro BRANCH_STAGE_STRIP_EN: clear the routing bit in the
//   latched packet. Routing always uses the raw PACKET_IN bit.
//
//   state     | meaning
//   ----------+-------------------------------------------------
//   IN_WAIT   | waiting for Send_in with the target channel idle
//   IN_ACK    | packet captured, Ack_out high until Send_in drops
//   OUT_IDLE  | channel latch free
//   OUT_REQ   | Send_out_x high, waiting for Ack_in_x
//   OUT_RTZ   | Send_out_x low, waiting for Ack_in_x to drop

`ifndef M_PACKET_WIDTH
`define M_PACKET_WIDTH 32
`endif
`ifndef M_PACKET_SIZE
`define M_PACKET_SIZE `M_PACKET_WIDTH
`endif

module branch_stage #(
   parameter int SEL_BIT = `M_PACKET_WIDTH - 1
) (
   input  logic            CLK,
   input  logic            MR_N,
   branch_stage_if.slave   bus
);

   typedef enum logic       {IN_WAIT, IN_ACK} in_state_t;
   typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_RTZ} out_state_t;

   in_state_t                 r_in_state;
   out_state_t                r_out_a;
   out_state_t                r_out_b;
   logic                      r_ack;
   logic                      r_send_a;
   logic                      r_send_b;
   logic [`M_PACKET_SIZE-1:0] r_dl_a;
   logic [`M_PACKET_SIZE-1:0] r_dl_b;

   logic                      w_sel;
   logic                      w_cap;
   logic                      w_cap_a;
   logic                      w_cap_b;
   logic [`M_PACKET_SIZE-1:0] w_latch_pkt;

   assign w_sel   = bus.PACKET_IN[SEL_BIT];
   // Head-of-line: only the target channel's state gates the capture.
   assign w_cap   = (r_in_state == IN_WAIT) && bus.Send_in &&
                    (w_sel ? (r_out_b == OUT_IDLE) : (r_out_a == OUT_IDLE));
   assign w_cap_a = w_cap && !w_sel;
   assign w_cap_b = w_cap &&  w_sel;

   always_comb begin
      w_latch_pkt = bus.PACKET_IN;
`ifdef BRANCH_STAGE_STRIP_EN
      w_latch_pkt[SEL_BIT] = 1'b0;
`endif
   end

   always_ff @(posedge CLK) begin
      if (!MR_N) begin
         r_in_state <= IN_WAIT;
         r_out_a    <= OUT_IDLE;
         r_out_b    <= OUT_IDLE;
         r_ack      <= 1'b0;
         r_send_a   <= 1'b0;
         r_send_b   <= 1'b0;
         r_dl_a     <= '0;
         r_dl_b     <= '0;
      end else begin
         case (r_in_state)
            IN_WAIT: if (w_cap) begin
               r_in_state <= IN_ACK;
               r_ack      <= 1'b1;
            end
            IN_ACK: if (!bus.Send_in) begin
               r_in_state <= IN_WAIT;
               r_ack      <= 1'b0;
            end
            default: r_in_state <= IN_WAIT;
         endcase

         case (r_out_a)
            OUT_IDLE: if (w_cap_a) begin
               r_out_a  <= OUT_REQ;
               r_send_a <= 1'b1;
               r_dl_a   <= w_latch_pkt;
            end
            OUT_REQ: if (bus.Ack_in_a) begin
               r_out_a  <= OUT_RTZ;
               r_send_a <= 1'b0;
            end
            OUT_RTZ: if (!bus.Ack_in_a) r_out_a <= OUT_IDLE;
            default: begin
               r_out_a  <= OUT_IDLE;
               r_send_a <= 1'b0;
            end
         endcase

         case (r_out_b)
            OUT_IDLE: if (w_cap_b) begin
               r_out_b  <= OUT_REQ;
               r_send_b <= 1'b1;
               r_dl_b   <= w_latch_pkt;
            end
            OUT_REQ: if (bus.Ack_in_b) begin
               r_out_b  <= OUT_RTZ;
               r_send_b <= 1'b0;
            end
            OUT_RTZ: if (!bus.Ack_in_b) r_out_b <= OUT_IDLE;
            default: begin
               r_out_b  <= OUT_IDLE;
               r_send_b <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Ack_out      = r_ack;
   assign bus.Send_out_a   = r_send_a;
   assign bus.Send_out_b   = r_send_b;
   assign bus.PACKET_OUT_A = r_dl_a;
   assign bus.PACKET_OUT_B = r_dl_b;

endmodule

// File: tb/tb_branch_stage.sv
// tb_branch_stage
//   Directed scenarios for branch_stage with SEL_BIT=31. Expected packets are
//   pushed per channel when a capture is provoked and popped when the
//   matching Send_out_x is seen high.

module tb_branch_stage;

   logic clk;
   logic mr_n;
   int   n_vec;
   int   n_err;

   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] exp_v;

   branch_stage_if bus ();

   branch_stage #(.SEL_BIT(31)) dut (
      .CLK  (clk),
      .MR_N (mr_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] model_latch(input logic [31:0] p);
      logic [31:0] r;
      r = p;
`ifdef BRANCH_STAGE_STRIP_EN
      r[31] = 1'b0;
`endif
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives a handshake through one channel's RTZ cycle back to idle.
   task automatic finish_ch(input bit ch_b);
      if (ch_b) bus.Ack_in_b = 1'b1; else bus.Ack_in_a = 1'b1;
      step();
      if (ch_b) bus.Ack_in_b = 1'b0; else bus.Ack_in_a = 1'b0;
      step();
   endtask

   task automatic test_reset();
      mr_n = 1'b0;
      bus.Send_in   = 1'b1;
      bus.PACKET_IN = 32'hFFFF_FFFF;
      step();
      step();
      n_vec++;
      if ({bus.Ack_out, bus.Send_out_a, bus.Send_out_b} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_ctrl got %b want 000", {bus.Ack_out, bus.Send_out_a, bus.Send_out_b});
      end
      n_vec++;
      if (bus.PACKET_OUT_A !== 32'h0 || bus.PACKET_OUT_B !== 32'h0) begin
         n_err++;
         $display("FAIL reset_data got %h/%h want 0/0", bus.PACKET_OUT_A, bus.PACKET_OUT_B);
      end
      mr_n = 1'b1;
      q_b.push_back(model_latch(32'hFFFF_FFFF));
      step();
      n_vec++;
      if (bus.Ack_out !== 1'b1 || bus.Send_out_b !== 1'b1 || bus.Send_out_a !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release ack=%b sa=%b sb=%b want 1 0 1", bus.Ack_out, bus.Send_out_a, bus.Send_out_b);
      end
      if (bus.Send_out_b === 1'b1) begin
         n_vec++;
         if (q_b.size() == 0) begin
            n_err++;
            $display("FAIL reset_sb empty queue got %h", bus.PACKET_OUT_B);
         end else begin
            exp_v = q_b.pop_front();
            if (bus.PACKET_OUT_B !== exp_v) begin
               n_err++;
               $display("FAIL reset_pkt got %h want %h", bus.PACKET_OUT_B, exp_v);
            end
         end
      end
      bus.Send_in = 1'b0;
      step();
      finish_ch(1'b1);
   endtask

   task automatic test_route_a();
      bus.PACKET_IN = 32'h0000_1234;
      bus.Send_in   = 1'b1;
      q_a.push_back(model_latch(32'h0000_1234));
      step();
      n_vec++;
      if ({bus.Ack_out, bus.Send_out_a, bus.Send_out_b} !== 3'b110) begin
         n_err++;
         $display("FAIL route_a_ctrl got %b want 110", {bus.Ack_out, bus.Send_out_a, bus.Send_out_b});
      end
      n_vec++;
      if (q_a.size() == 0) begin
         n_err++;
         $display("FAIL route_a_sb empty queue got %h", bus.PACKET_OUT_A);
      end else begin
         exp_v = q_a.pop_front();
         if (bus.PACKET_OUT_A !== exp_v) begin
            n_err++;
            $display("FAIL route_a_pkt got %h want %h", bus.PACKET_OUT_A, exp_v);
         end
      end
      bus.Send_in = 1'b0;
      step();
      n_vec++;
      if (bus.Ack_out !== 1'b0 || bus.Send_out_a !== 1'b1) begin
         n_err++;
         $display("FAIL route_a_ackdrop ack=%b sa=%b want 0 1", bus.Ack_out, bus.Send_out_a);
      end
      bus.Ack_in_a = 1'b1;
      step();
      n_vec++;
      if (bus.Send_out_a !== 1'b0) begin
         n_err++;
         $display("FAIL route_a_rtz got %b want 0", bus.Send_out_a);
      end
      bus.Ack_in_a = 1'b0;
      step();
      // Channel is idle now: the next A packet must be captured at once.
      bus.PACKET_IN = 32'h0000_5678;
      bus.Send_in   = 1'b1;
      q_a.push_back(model_latch(32'h0000_5678));
      step();
      n_vec++;
      if (bus.Ack_out !== 1'b1 || bus.Send_out_a !== 1'b1) begin
         n_err++;
         $display("FAIL route_a_reuse ack=%b sa=%b want 1 1", bus.Ack_out, bus.Send_out_a);
      end
      n_vec++;
      if (q_a.size() == 0) begin
         n_err++;
         $display("FAIL route_a2_sb empty queue got %h", bus.PACKET_OUT_A);
      end else begin
         exp_v = q_a.pop_front();
         if (bus.PACKET_OUT_A !== exp_v) begin
            n_err++;
            $display("FAIL route_a2_pkt got %h want %h", bus.PACKET_OUT_A, exp_v);
         end
      end
      bus.Send_in = 1'b0;
      step();
      finish_ch(1'b0);
   endtask

   task automatic test_route_b();
      bus.PACKET_IN = 32'h8000_00AB;
      bus.Send_in   = 1'b1;
      q_b.push_back(model_latch(32'h8000_00AB));
      step();
      n_vec++;
      if ({bus.Ack_out, bus.Send_out_a, bus.Send_out_b} !== 3'b101) begin
         n_err++;
         $display("FAIL route_b_ctrl got %b want 101", {bus.Ack_out, bus.Send_out_a, bus.Send_out_b});
      end
      n_vec++;
      if (q_b.size() == 0) begin
         n_err++;
         $display("FAIL route_b_sb empty queue got %h", bus.PACKET_OUT_B);
      end else begin
         exp_v = q_b.pop_front();
         if (bus.PACKET_OUT_B !== exp_v) begin
            n_err++;
            $display("FAIL route_b_pkt got %h want %h", bus.PACKET_OUT_B, exp_v);
         end
      end
      bus.Send_in = 1'b0;
      step();
      finish_ch(1'b1);
   endtask

   task automatic test_blocking();
      logic [31:0] held;
      bus.PACKET_IN = 32'h8000_0010;
      bus.Send_in   = 1'b1;
      held = model_latch(32'h8000_0010);
      step();
      bus.Send_in = 1'b0;
      step();
      bus.PACKET_IN = 32'h8000_0001;
      bus.Send_in   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_vec++;
         if (bus.Ack_out !== 1'b0 || bus.PACKET_OUT_B !== held) begin
            n_err++;
            $display("FAIL block_hold cyc %0d ack=%b pkt=%h want 0 %h", i, bus.Ack_out, bus.PACKET_OUT_B, held);
         end
      end
      bus.Ack_in_b = 1'b1;
      step();
      bus.Ack_in_b = 1'b0;
      step();
      n_vec++;
      if (bus.Ack_out !== 1'b0 || bus.Send_out_b !== 1'b0) begin
         n_err++;
         $display("FAIL block_rtz_edge ack=%b sb=%b want 0 0", bus.Ack_out, bus.Send_out_b);
      end
      q_b.push_back(model_latch(32'h8000_0001));
      step();
      n_vec++;
      if (bus.Ack_out !== 1'b1 || bus.Send_out_b !== 1'b1) begin
         n_err++;
         $display("FAIL block_release ack=%b sb=%b want 1 1", bus.Ack_out, bus.Send_out_b);
      end
      n_vec++;
      if (q_b.size() == 0) begin
         n_err++;
         $display("FAIL block_sb empty queue got %h", bus.PACKET_OUT_B);
      end else begin
         exp_v = q_b.pop_front();
         if (bus.PACKET_OUT_B !== exp_v) begin
            n_err++;
            $display("FAIL block_pkt got %h want %h", bus.PACKET_OUT_B, exp_v);
         end
      end
      bus.Send_in = 1'b0;
      step();
      finish_ch(1'b1);
   endtask

   task automatic test_concurrency();
      bus.PACKET_IN = 32'h0000_00A1;
      bus.Send_in   = 1'b1;
      q_a.push_back(model_latch(32'h0000_00A1));
      step();
      bus.Send_in = 1'b0;
      step();
      bus.PACKET_IN = 32'h8000_00B2;
      bus.Send_in   = 1'b1;
      q_b.push_back(model_latch(32'h8000_00B2));
      step();
      n_vec++;
      if ({bus.Ack_out, bus.Send_out_a, bus.Send_out_b} !== 3'b111) begin
         n_err++;
         $display("FAIL conc_both got %b want 111", {bus.Ack_out, bus.Send_out_a, bus.Send_out_b});
      end
      n_vec++;
      if (q_a.size() == 0 || q_b.size() == 0) begin
         n_err++;
         $display("FAIL conc_sb empty queue got %h/%h", bus.PACKET_OUT_A, bus.PACKET_OUT_B);
      end else begin
         exp_v = q_a.pop_front();
         if (bus.PACKET_OUT_A !== exp_v) begin
            n_err++;
            $display("FAIL conc_pkt_a got %h want %h", bus.PACKET_OUT_A, exp_v);
         end
         exp_v = q_b.pop_front();
         if (bus.PACKET_OUT_B !== exp_v) begin
            n_err++;
            $display("FAIL conc_pkt_b got %h want %h", bus.PACKET_OUT_B, exp_v);
         end
      end
      bus.Send_in  = 1'b0;
      bus.Ack_in_a = 1'b1;
      step();
      n_vec++;
      if (bus.Send_out_a !== 1'b0 || bus.Send_out_b !== 1'b1) begin
         n_err++;
         $display("FAIL conc_a_done sa=%b sb=%b want 0 1", bus.Send_out_a, bus.Send_out_b);
      end
      bus.Ack_in_a = 1'b0;
      bus.Ack_in_b = 1'b1;
      step();
      n_vec++;
      if (bus.Send_out_a !== 1'b0 || bus.Send_out_b !== 1'b0) begin
         n_err++;
         $display("FAIL conc_b_done sa=%b sb=%b want 0 0", bus.Send_out_a, bus.Send_out_b);
      end
      bus.Ack_in_b = 1'b0;
      step();
   endtask

   task automatic test_mid_reset();
      bus.PACKET_IN = 32'h0000_0C0D;
      bus.Send_in   = 1'b1;
      step();
      mr_n = 1'b0;
      step();
      n_vec++;
      if ({bus.Ack_out, bus.Send_out_a, bus.Send_out_b} !== 3'b000 ||
          bus.PACKET_OUT_A !== 32'h0) begin
         n_err++;
         $display("FAIL midrst got ctrl=%b pa=%h want 000 0",
                  {bus.Ack_out, bus.Send_out_a, bus.Send_out_b}, bus.PACKET_OUT_A);
      end
      mr_n = 1'b1;
      bus.Send_in  = 1'b0;
      bus.Ack_in_a = 1'b1;
      step();
      step();
      n_vec++;
      if (bus.Send_out_a !== 1'b0 || bus.Ack_out !== 1'b0 || bus.PACKET_OUT_A !== 32'h0) begin
         n_err++;
         $display("FAIL midrst_stray sa=%b ack=%b pa=%h want 0 0 0", bus.Send_out_a, bus.Ack_out, bus.PACKET_OUT_A);
      end
      bus.Ack_in_a  = 1'b0;
      bus.PACKET_IN = 32'h0000_0E0F;
      bus.Send_in   = 1'b1;
      q_a.push_back(model_latch(32'h0000_0E0F));
      step();
      n_vec++;
      if (q_a.size() == 0) begin
         n_err++;
         $display("FAIL midrst_sb empty queue got %h", bus.PACKET_OUT_A);
      end else begin
         exp_v = q_a.pop_front();
         if (bus.Send_out_a !== 1'b1 || bus.PACKET_OUT_A !== exp_v) begin
            n_err++;
            $display("FAIL midrst_restart sa=%b pa=%h want 1 %h", bus.Send_out_a, bus.PACKET_OUT_A, exp_v);
         end
      end
      bus.Send_in = 1'b0;
      step();
      finish_ch(1'b0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      mr_n          = 1'b0;
      bus.Send_in   = 1'b0;
      bus.PACKET_IN = 32'h0;
      bus.Ack_in_a  = 1'b0;
      bus.Ack_in_b  = 1'b0;
      step();
      test_reset();
      test_route_a();
      test_route_b();
      test_blocking();
      test_concurrency();
      test_mid_reset();
      n_vec++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain left a=%0d b=%0d want 0 0", q_a.size(), q_b.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
